// File: rtl/mem_arbiter.sv
// Byte-wide RAM port arbiter: serialises i-cache word fetches and load/store
// buffer accesses into little-endian byte cycles, with I/O write back-pressure.
//
// state | meaning
// IDLE  | port free, arbitrating between i-cache and load/store buffer
// READ  | issuing byte reads and capturing returned bytes
// WRITE | issuing byte writes, stalling on a full I/O buffer
// DONE  | one-cycle rdy pulse to the granted requester
module mem_arbiter #(
    parameter logic [1:0] IO_SEL = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        ic_ins_asked,
    input  logic [31:0] ic_ins_addr,
    output logic        ic_enable,
    output logic        ic_ins_rdy,
    output logic [31:0] ic_ins,
    input  logic        flush,
    input  logic        lsb_asked,
    input  logic        lsb_wr,
    input  logic [31:0] lsb_addr,
    input  logic [1:0]  lsb_width,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_rdy,
    output logic [31:0] lsb_rdata
);

    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;

    state_t      state_q, state_d;
    logic [2:0]  i_q, i_d, j_q, j_d, n_q, n_d;
    logic        is_ic_q, is_ic_d, last_lsb_q, last_lsb_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, buf_q, buf_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;
    logic [31:0] ic_ins_q, ic_ins_d, lsb_rdata_q, lsb_rdata_d;
    logic        ic_rdy_q, ic_rdy_d, lsb_rdy_q, lsb_rdy_d;

    logic [31:0] cap;
    logic [7:0]  wbyte;
    logic        io_stall;
    logic        lsb_first;

    function automatic logic [2:0] nbytes(input logic [1:0] w);
        case (w)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        n_d         = n_q;
        is_ic_d     = is_ic_q;
        last_lsb_d  = last_lsb_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        mem_a_d     = mem_a_q;
        mem_dout_d  = mem_dout_q;
        mem_wr_d    = mem_wr_q;
        ic_ins_d    = ic_ins_q;
        lsb_rdata_d = lsb_rdata_q;
        ic_rdy_d    = ic_rdy_q;
        lsb_rdy_d   = lsb_rdy_q;

        // Alternate priority: the i-cache gets a turn right after an LSB grant.
        lsb_first = lsb_asked && !(last_lsb_q && ic_ins_asked);
        io_stall  = (addr_q[17:16] == IO_SEL) && io_buffer_full;

        case (i_q[1:0])
            2'd0:    wbyte = wdata_q[7:0];
            2'd1:    wbyte = wdata_q[15:8];
            2'd2:    wbyte = wdata_q[23:16];
            default: wbyte = wdata_q[31:24];
        endcase

        cap = buf_q;
        case (j_q[1:0])
            2'd0:    cap[7:0]   = mem_din;
            2'd1:    cap[15:8]  = mem_din;
            2'd2:    cap[23:16] = mem_din;
            default: cap[31:24] = mem_din;
        endcase

        case (state_q)
            IDLE: begin
                if (lsb_first) begin
                    is_ic_d    = 1'b0;
                    last_lsb_d = 1'b1;
                    addr_d     = lsb_addr;
                    wdata_d    = lsb_wdata;
                    n_d        = nbytes(lsb_width);
                    buf_d      = 32'h0;
                    j_d        = 3'd0;
                    if (lsb_wr) begin
                        state_d = WRITE;
                        if ((lsb_addr[17:16] == IO_SEL) && io_buffer_full) begin
                            mem_wr_d = 1'b0;
                            i_d      = 3'd0;
                        end else begin
                            mem_wr_d   = 1'b1;
                            mem_a_d    = lsb_addr;
                            mem_dout_d = lsb_wdata[7:0];
                            i_d        = 3'd1;
                        end
                    end else begin
                        state_d  = READ;
                        mem_a_d  = lsb_addr;
                        mem_wr_d = 1'b0;
                        i_d      = 3'd1;
                    end
                end else if (ic_ins_asked) begin
                    is_ic_d    = 1'b1;
                    last_lsb_d = 1'b0;
                    addr_d     = ic_ins_addr;
                    n_d        = 3'd4;
                    buf_d      = 32'h0;
                    j_d        = 3'd0;
                    i_d        = 3'd1;
                    mem_a_d    = ic_ins_addr;
                    mem_wr_d   = 1'b0;
                    state_d    = READ;
                end
            end
            READ: begin
                if (is_ic_q && flush) begin
                    state_d  = IDLE;
                    mem_wr_d = 1'b0;
                end else begin
                    if (i_q < n_q) begin
                        mem_a_d = addr_q + {29'd0, i_q};
                    end
                    i_d = i_q + 3'd1;
                    // RAM answers one cycle late, so capture lags issue by two edges.
                    if (i_q >= 3'd2) begin
                        buf_d = cap;
                        j_d   = j_q + 3'd1;
                        if (j_q == n_q - 3'd1) begin
                            state_d = DONE;
                            if (is_ic_q) begin
                                ic_ins_d = cap;
                                ic_rdy_d = 1'b1;
                            end else begin
                                lsb_rdata_d = cap;
                                lsb_rdy_d   = 1'b1;
                            end
                        end
                    end
                end
            end
            WRITE: begin
                if (i_q < n_q) begin
                    if (io_stall) begin
                        mem_wr_d = 1'b0;
                    end else begin
                        mem_wr_d   = 1'b1;
                        mem_a_d    = addr_q + {29'd0, i_q};
                        mem_dout_d = wbyte;
                        i_d        = i_q + 3'd1;
                    end
                end else begin
                    mem_wr_d  = 1'b0;
                    lsb_rdy_d = 1'b1;
                    state_d   = DONE;
                end
            end
            default: begin
                ic_rdy_d  = 1'b0;
                lsb_rdy_d = 1'b0;
                mem_wr_d  = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            i_q         <= 3'd0;
            j_q         <= 3'd0;
            n_q         <= 3'd0;
            is_ic_q     <= 1'b0;
            last_lsb_q  <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            buf_q       <= 32'h0;
            mem_a_q     <= 32'h0;
            mem_dout_q  <= 8'h0;
            mem_wr_q    <= 1'b0;
            ic_ins_q    <= 32'h0;
            lsb_rdata_q <= 32'h0;
            ic_rdy_q    <= 1'b0;
            lsb_rdy_q   <= 1'b0;
        end else if (rdy) begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            n_q         <= n_d;
            is_ic_q     <= is_ic_d;
            last_lsb_q  <= last_lsb_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            mem_a_q     <= mem_a_d;
            mem_dout_q  <= mem_dout_d;
            mem_wr_q    <= mem_wr_d;
            ic_ins_q    <= ic_ins_d;
            lsb_rdata_q <= lsb_rdata_d;
            ic_rdy_q    <= ic_rdy_d;
            lsb_rdy_q   <= lsb_rdy_d;
        end
    end

    assign ic_enable  = (state_q == IDLE) && !rst;
    assign mem_a      = mem_a_q;
    assign mem_dout   = mem_dout_q;
    assign mem_wr     = mem_wr_q;
    assign ic_ins     = ic_ins_q;
    assign ic_ins_rdy = ic_rdy_q;
    assign lsb_rdata  = lsb_rdata_q;
    assign lsb_rdy    = lsb_rdy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency RAM model and
// queue scoreboards for i-cache and load/store results.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr, io_buffer_full;
    logic        ic_ins_asked, ic_enable, ic_ins_rdy, flush;
    logic [31:0] ic_ins_addr, ic_ins;
    logic        lsb_asked, lsb_wr, lsb_rdy;
    logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;
    logic [1:0]  lsb_width;

    typedef struct packed {
        logic        st;
        logic [31:0] d;
    } lsb_exp_t;

    logic [31:0] ic_q[$];
    lsb_exp_t    lsb_q[$];
    int          total = 0;
    int          bad = 0;
    int          lsb_pulses = 0;
    int          lsb_pushed = 0;
    logic [31:0] last_ic = 32'h0;
    logic [7:0]  ram [1024];

    mem_arbiter #(.IO_SEL(2'b11)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .ic_ins_asked(ic_ins_asked), .ic_ins_addr(ic_ins_addr), .ic_enable(ic_enable),
        .ic_ins_rdy(ic_ins_rdy), .ic_ins(ic_ins), .flush(flush),
        .lsb_asked(lsb_asked), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_width(lsb_width),
        .lsb_wdata(lsb_wdata), .lsb_rdy(lsb_rdy), .lsb_rdata(lsb_rdata)
    );

    always #5 clk = ~clk;

    // RAM shares the global enable so frozen cycles do not skew read data.
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 1024; k++) ram[k] <= 8'h00;
            ram[10'h100] <= 8'h13;
            ram[10'h200] <= 8'h44;
            ram[10'h201] <= 8'h33;
            ram[10'h202] <= 8'hFF;
            ram[10'h203] <= 8'h80;
            ram[10'h204] <= 8'h11;
            ram[10'h205] <= 8'h22;
            mem_din      <= 8'h00;
        end else if (rdy) begin
            if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
            mem_din <= ram[mem_a[9:0]];
        end
    end

    always @(posedge clk) begin
        #1;
        if (!rst && ic_ins_rdy) begin
            total++;
            assert (ic_q.size() > 0) else begin
                bad++;
                $error("FAIL ic_unexpected got=%h exp=none", ic_ins);
            end
            if (ic_q.size() > 0) begin
                last_ic = ic_q.pop_front();
                total++;
                assert (ic_ins === last_ic) else begin
                    bad++;
                    $error("FAIL ic_data got=%h exp=%h", ic_ins, last_ic);
                end
            end
        end
        if (!rst && lsb_rdy) begin
            lsb_exp_t e;
            lsb_pulses++;
            if (lsb_q.size() > 0) begin
                e = lsb_q.pop_front();
                if (!e.st) begin
                    total++;
                    assert (lsb_rdata === e.d) else begin
                        bad++;
                        $error("FAIL lsb_data got=%h exp=%h", lsb_rdata, e.d);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_ic(input int max);
        int n = 0;
        while (ic_ins_rdy !== 1'b1 && n < max) begin
            step();
            n++;
        end
        check("ic_timeout", {31'd0, ic_ins_rdy}, 32'd1);
    endtask

    task automatic wait_lsb(input int max);
        int n = 0;
        while (lsb_rdy !== 1'b1 && n < max) begin
            step();
            n++;
        end
        check("lsb_timeout", {31'd0, lsb_rdy}, 32'd1);
    endtask

    task automatic push_lsb(input logic st, input logic [31:0] d);
        lsb_exp_t e;
        e.st = st;
        e.d  = d;
        lsb_q.push_back(e);
        lsb_pushed++;
    endtask

    initial begin
        logic [31:0] w;
        rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0; flush = 1'b0;
        ic_ins_asked = 1'b0; ic_ins_addr = 32'h0;
        lsb_asked = 1'b0; lsb_wr = 1'b0; lsb_addr = 32'h0; lsb_width = 2'd0; lsb_wdata = 32'h0;
        repeat (3) step();
        check("rst_ic_enable", {31'd0, ic_enable}, 32'd0);
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_mem_dout", {24'd0, mem_dout}, 32'h0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_rdys", {30'd0, ic_ins_rdy, lsb_rdy}, 32'd0);
        check("rst_ic_ins", ic_ins, 32'h0);
        check("rst_lsb_rdata", lsb_rdata, 32'h0);
        rst = 1'b0;
        step();
        check("idle_ic_enable", {31'd0, ic_enable}, 32'd1);

        // i-cache word fetch
        ic_q.push_back(32'h0000_0013);
        ic_ins_asked = 1'b1; ic_ins_addr = 32'h100;
        step();
        check("f_e0_mem_a", mem_a, 32'h100);
        check("f_e0_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("f_e0_ic_enable", {31'd0, ic_enable}, 32'd0);
        for (int k = 1; k < 4; k++) begin
            step();
            check("f_mem_a", mem_a, 32'h100 + k);
        end
        step();
        check("f_e4_rdy", {31'd0, ic_ins_rdy}, 32'd0);
        step();
        check("f_e5_rdy", {31'd0, ic_ins_rdy}, 32'd1);
        check("f_e5_ic_enable", {31'd0, ic_enable}, 32'd0);
        ic_ins_asked = 1'b0;
        step();
        check("f_e6_rdy", {31'd0, ic_ins_rdy}, 32'd0);
        check("f_e6_ic_enable", {31'd0, ic_enable}, 32'd1);

        // both requesters together, then alternation
        push_lsb(1'b0, 32'h0000_0013);
        ic_q.push_back(32'h2211_80FF);
        lsb_asked = 1'b1; lsb_addr = 32'h100; lsb_width = 2'd0;
        ic_ins_asked = 1'b1; ic_ins_addr = 32'h202;
        step();
        check("arb_first_lsb", mem_a, 32'h100);
        wait_lsb(10);
        lsb_asked = 1'b0;
        step();
        push_lsb(1'b0, 32'h0000_0080);
        lsb_asked = 1'b1; lsb_addr = 32'h203;
        step();
        check("arb_alt_ic", mem_a, 32'h202);
        wait_ic(10);
        ic_ins_asked = 1'b0;
        wait_lsb(12);
        lsb_asked = 1'b0;
        step();

        // half load
        push_lsb(1'b0, 32'h0000_80FF);
        lsb_asked = 1'b1; lsb_addr = 32'h202; lsb_width = 2'd1;
        step();
        check("h_e0_mem_a", mem_a, 32'h202);
        step();
        check("h_e1_mem_a", mem_a, 32'h203);
        step();
        check("h_e2_rdy", {31'd0, lsb_rdy}, 32'd0);
        step();
        check("h_e3_rdy", {31'd0, lsb_rdy}, 32'd1);
        lsb_asked = 1'b0;
        step();
        check("h_e4_rdy", {31'd0, lsb_rdy}, 32'd0);

        // word store and readback with width code 3
        w = 32'hDEAD_BEEF;
        push_lsb(1'b1, 32'h0);
        lsb_asked = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h40; lsb_width = 2'd2; lsb_wdata = w;
        for (int k = 0; k < 4; k++) begin
            step();
            check("s_mem_wr", {31'd0, mem_wr}, 32'd1);
            check("s_mem_a", mem_a, 32'h40 + k);
            check("s_mem_dout", {24'd0, mem_dout}, {24'd0, w[8*k +: 8]});
        end
        step();
        check("s_e4_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("s_e4_rdy", {31'd0, lsb_rdy}, 32'd1);
        lsb_asked = 1'b0; lsb_wr = 1'b0;
        step();
        push_lsb(1'b0, w);
        lsb_asked = 1'b1; lsb_addr = 32'h40; lsb_width = 2'd3;
        wait_lsb(10);
        lsb_asked = 1'b0;
        step();

        // I/O byte store stalled by a full buffer
        push_lsb(1'b1, 32'h0);
        io_buffer_full = 1'b1;
        lsb_asked = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h0003_0000; lsb_width = 2'd0;
        lsb_wdata = 32'h0000_005A;
        for (int k = 0; k < 5; k++) begin
            step();
            check("io_stall_wr", {31'd0, mem_wr}, 32'd0);
        end
        io_buffer_full = 1'b0;
        step();
        check("io_wr", {31'd0, mem_wr}, 32'd1);
        check("io_mem_a", mem_a, 32'h0003_0000);
        check("io_dout", {24'd0, mem_dout}, 32'h5A);
        step();
        check("io_rdy", {31'd0, lsb_rdy}, 32'd1);
        check("io_wr_off", {31'd0, mem_wr}, 32'd0);
        lsb_asked = 1'b0; lsb_wr = 1'b0;
        step();
        check("io_rdy_off", {31'd0, lsb_rdy}, 32'd0);

        // flushed fetch, then an immediate fetch
        ic_ins_asked = 1'b1; ic_ins_addr = 32'h100;
        repeat (3) step();
        flush = 1'b1; ic_ins_asked = 1'b0;
        step();
        check("fl_idle", {31'd0, ic_enable}, 32'd1);
        check("fl_no_rdy", {31'd0, ic_ins_rdy}, 32'd0);
        check("fl_ic_ins", ic_ins, last_ic);
        flush = 1'b0;
        ic_q.push_back(32'h80FF_3344);
        ic_ins_asked = 1'b1; ic_ins_addr = 32'h200;
        wait_ic(10);
        ic_ins_asked = 1'b0;
        step();

        // global enable dropped mid-read
        ic_q.push_back(32'h2211_80FF);
        ic_ins_asked = 1'b1; ic_ins_addr = 32'h202;
        repeat (2) step();
        rdy = 1'b0;
        repeat (3) step();
        check("rdy_hold_mem_a", mem_a, 32'h203);
        rdy = 1'b1;
        repeat (3) step();
        check("rdy_late_no_pulse", {31'd0, ic_ins_rdy}, 32'd0);
        step();
        check("rdy_late_pulse", {31'd0, ic_ins_rdy}, 32'd1);
        ic_ins_asked = 1'b0;
        repeat (3) step();

        check("ic_queue_empty", ic_q.size(), 32'd0);
        check("lsb_queue_empty", lsb_q.size(), 32'd0);
        check("lsb_pulse_count", lsb_pulses, lsb_pushed);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
